// File: rtl/mux3_burst_arbiter.sv
// Three-requester burst arbiter with registered select/grant and a 1-deep valid/ready output stage.
// Define MUX3_ARB_FIXED_PRIO_EN for fixed priority (0 > 1 > 2) instead of round-robin.
module mux3_burst_arbiter #(
   parameter int WIDTH     = 8,
   parameter int MAX_BURST = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [2:0]       req,
   input  logic [2:0]       last,
   input  logic [WIDTH-1:0] data0,
   input  logic [WIDTH-1:0] data1,
   input  logic [WIDTH-1:0] data2,
   output logic [2:0]       gnt,
   output logic [2:0]       sel,
   output logic [2:0]       ack,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic             busy
);

   localparam int CW = $clog2(MAX_BURST + 1);
   localparam logic [CW:0] MAX_B = (CW + 1)'(MAX_BURST);

   typedef enum logic {IDLE, GRANT} state_e;

   state_e           state_q, state_d;
   logic [2:0]       gnt_q, gnt_d;
   logic [2:0]       sel_q, sel_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;

   logic             load, acc, req_g, last_g, cnt_hit;
   logic [CW:0]      cnt_inc;
   logic [WIDTH-1:0] sel_data;
   logic [1:0]       pick;
   logic [1:0]       g_next;

   assign load    = ~out_valid_q | out_ready;
   assign ack     = gnt_q & req & {3{load}};
   assign acc     = |ack;
   assign req_g   = |(gnt_q & req);
   assign last_g  = |(gnt_q & last);
   assign cnt_inc = {1'b0, cnt_q} + {{CW{1'b0}}, 1'b1};
   assign cnt_hit = (cnt_inc == MAX_B);

   always_comb begin
      case (sel_q)
         3'b001:  sel_data = data1;
         3'b010:  sel_data = data2;
         default: sel_data = data0;
      endcase
   end

   always_comb begin
      case (sel_q)
         3'b001:  g_next = 2'd2;
         3'b010:  g_next = 2'd0;
         default: g_next = 2'd1;
      endcase
   end

`ifdef MUX3_ARB_FIXED_PRIO_EN
   always_comb begin
      if (req[0])      pick = 2'd0;
      else if (req[1]) pick = 2'd1;
      else             pick = 2'd2;
   end
`else
   logic [1:0] rr_q, rr_d;

   // Scan order starts at rr and wraps modulo 3.
   always_comb begin
      pick = 2'd0;
      case (rr_q)
         2'd1: begin
            if (req[1])      pick = 2'd1;
            else if (req[2]) pick = 2'd2;
            else             pick = 2'd0;
         end
         2'd2: begin
            if (req[2])      pick = 2'd2;
            else if (req[0]) pick = 2'd0;
            else             pick = 2'd1;
         end
         default: begin
            if (req[0])      pick = 2'd0;
            else if (req[1]) pick = 2'd1;
            else             pick = 2'd2;
         end
      endcase
   end
`endif

   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      sel_d       = sel_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
`ifndef MUX3_ARB_FIXED_PRIO_EN
      rr_d        = rr_q;
`endif
      if (acc) begin
         out_data_d  = sel_data;
         out_valid_d = 1'b1;
         cnt_d       = cnt_inc[CW-1:0];
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
      case (state_q)
         IDLE: begin
            if (|req) begin
               state_d = GRANT;
               gnt_d   = 3'b001 << pick;
               sel_d   = {1'b0, pick};
               cnt_d   = '0;
            end
         end
         GRANT: begin
            // An abandon (req dropped) never coincides with acc, so it wins over the limit.
            if (!req_g || (acc && (last_g || cnt_hit))) begin
               state_d = IDLE;
               gnt_d   = 3'b000;
               sel_d   = 3'b000;
`ifndef MUX3_ARB_FIXED_PRIO_EN
               rr_d    = g_next;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         gnt_q       <= 3'b000;
         sel_q       <= 3'b000;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         sel_q       <= sel_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

`ifndef MUX3_ARB_FIXED_PRIO_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rr_q <= 2'd0;
      else        rr_q <= rr_d;
   end
`else
   logic unused_g_next;
   assign unused_g_next = ^g_next;
`endif

   assign gnt       = gnt_q;
   assign sel       = sel_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign busy      = (state_q == GRANT);

endmodule

// File: tb/tb_mux3_burst_arbiter.sv
// Random + directed bench for mux3_burst_arbiter against a transaction-level reference model.
module tb_mux3_burst_arbiter;
   localparam int W  = 8;
   localparam int MB = 4;

   logic clk = 1'b0, rst_n = 1'b0;
   logic [2:0] req = '0, last = '0;
   logic [W-1:0] d0 = '0, d1 = '0, d2 = '0;
   logic out_ready = 1'b1;
   logic [2:0] gnt, sel, ack;
   logic out_valid, busy;
   logic [W-1:0] out_data;

   mux3_burst_arbiter #(.WIDTH(W), .MAX_BURST(MB)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .last(last),
      .data0(d0), .data1(d1), .data2(d2),
      .gnt(gnt), .sel(sel), .ack(ack),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .busy(busy));

   always #5 clk = ~clk;

   int n_chk = 0, n_pass = 0;

   // Model: granted requester (-1 = none), beats in this burst, rr pointer, output slot.
   int m_g = -1, m_cnt = 0, m_rr = 0;
   bit m_v = 1'b0, m_ld;
   logic [W-1:0] m_d = '0;
   int gq[$];
   int bq[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
   endtask

   function automatic logic [W-1:0] dsel(input int i);
      return (i == 0) ? d0 : (i == 1) ? d1 : d2;
   endfunction

   function automatic int pick_m(input logic [2:0] r);
`ifdef MUX3_ARB_FIXED_PRIO_EN
      for (int i = 0; i < 3; i++) if (r[i]) return i;
`else
      for (int k = 0; k < 3; k++) if (r[(m_rr + k) % 3]) return (m_rr + k) % 3;
`endif
      return -1;
   endfunction

   function automatic int tail(input int q[$]);
      return (q.size() == 0) ? -1 : q[q.size()-1];
   endfunction

   task automatic end_burst();
      bq.push_back(m_cnt);
      m_rr = (m_g + 1) % 3;
      m_g  = -1;
   endtask

   always begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_g = -1; m_cnt = 0; m_rr = 0; m_v = 1'b0; m_d = '0;
      end else begin
         m_ld = !m_v || out_ready;
         if (m_g < 0) begin
            if (out_ready) m_v = 1'b0;
            if (req != 3'b000) begin
               m_g = pick_m(req); m_cnt = 0; gq.push_back(m_g);
            end
         end else if (req[m_g] && m_ld) begin
            m_d = dsel(m_g); m_v = 1'b1; m_cnt++;
            if (last[m_g] || m_cnt == MB) end_burst();
         end else begin
            if (out_ready) m_v = 1'b0;
            if (!req[m_g]) end_burst();
         end
      end
   end

   always @(negedge clk) begin
      logic [2:0] e_gnt, e_sel, e_ack;
      e_gnt = (m_g < 0) ? 3'b000 : 3'(1 << m_g);
      e_sel = (m_g < 0) ? 3'b000 : 3'(m_g);
      e_ack = (m_g >= 0 && req[m_g] && (!m_v || out_ready)) ? 3'(1 << m_g) : 3'b000;
      chk("gnt", 32'(gnt), 32'(e_gnt));
      chk("sel", 32'(sel), 32'(e_sel));
      chk("ack", 32'(ack), 32'(e_ack));
      chk("busy", 32'(busy), 32'(m_g >= 0));
      chk("out_valid", 32'(out_valid), 32'(m_v));
      chk("out_data", 32'(out_data), 32'(m_d));
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic rnd_data();
      d0 = W'($urandom); d1 = W'($urandom); d2 = W'($urandom);
   endtask

   logic [W-1:0] saved;
   int budget;

   initial begin
      #3;
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_sel", 32'(sel), 0);
      chk("rst_ack", 32'(ack), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_data", 32'(out_data), 0);
      chk("rst_busy", 32'(busy), 0);
      @(negedge clk); #1 rst_n = 1'b1;

      // Everyone requests continuously; bursts run to the beat limit.
      gq.delete(); bq.delete();
      req = 3'b111; last = 3'b000; out_ready = 1'b1;
      repeat (20) begin rnd_data(); step(); end
      chk("rr_nq", 32'(gq.size() >= 4), 1);
      if (gq.size() >= 4) begin
`ifdef MUX3_ARB_FIXED_PRIO_EN
         chk("grant0", gq[0], 0); chk("grant1", gq[1], 0);
         chk("grant2", gq[2], 0); chk("grant3", gq[3], 0);
`else
         chk("grant0", gq[0], 0); chk("grant1", gq[1], 1);
         chk("grant2", gq[2], 2); chk("grant3", gq[3], 0);
`endif
      end
      if (bq.size() >= 3) begin
         chk("beats0", bq[0], MB); chk("beats1", bq[1], MB); chk("beats2", bq[2], MB);
      end else chk("beats_nq", bq.size(), 3);
      req = 3'b000;
      repeat (6) step();

      // Single-beat burst from requester 1.
      req = 3'b010; last = 3'b010; d1 = 8'hA5;
      step();
      chk("b_gnt", 32'(gnt), 32'b010);
      chk("b_sel", 32'(sel), 32'b001);
      chk("b_ack", 32'(ack), 32'b010);
      step();
      chk("b_out_valid", 32'(out_valid), 1);
      chk("b_out_data", 32'(out_data), 32'hA5);
      chk("b_busy", 32'(busy), 0);
      req = 3'b000; last = 3'b000;
      repeat (3) step();

      // Backpressure mid-burst.
      req = 3'b001; out_ready = 1'b1;
      step();
      rnd_data(); step();
      out_ready = 1'b0; saved = out_data;
      repeat (3) begin
         rnd_data(); step();
         chk("bp_hold", 32'(out_data), 32'(saved));
         chk("bp_ack", 32'(ack), 0);
         chk("bp_busy", 32'(busy), 1);
      end
      out_ready = 1'b1;
      budget = 12;
      while (busy && budget > 0) begin rnd_data(); step(); budget--; end
      chk("bp_timeout", 32'(budget > 0), 1);
      req = 3'b000;
      chk("bp_beats", tail(bq), MB);
      repeat (2) step();

      // Requester 2 abandons after two beats.
      req = 3'b100;
      step();
      rnd_data(); step();
      rnd_data(); step();
      req = 3'b000;
      #0 chk("ab_ack", 32'(ack), 0);
      step();
      chk("ab_busy", 32'(busy), 0);
      chk("ab_beats", tail(bq), 2);
      req = 3'b111;
      step();
      chk("ab_regrant", 32'(gnt), 32'b001);

      // Asynchronous reset with a beat in the output register.
      rnd_data(); step();
      chk("ar_pre_valid", 32'(out_valid), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_out_valid", 32'(out_valid), 0);
      chk("ar_gnt", 32'(gnt), 0);
      chk("ar_busy", 32'(busy), 0);
      @(negedge clk); #1 rst_n = 1'b1;
      step();
      chk("ar_first_gnt", 32'(gnt), 32'b001);
      chk("ar_first_model", tail(gq), 0);

      // Random traffic.
      repeat (600) begin
         req = 3'($urandom) | 3'($urandom);
         last = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
         out_ready = ($urandom_range(0, 3) != 0);
         rnd_data();
         step();
      end
      req = 3'b000;
      repeat (3) step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end
endmodule
